// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional round-robin arbitration is selected with the MEM_ARB_RR_EN macro (see mem_arb_pick).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_DEF  = 255;

  // The requester that is not 'o'; used to alternate on ties.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: fetch port, load/store port,
// shared memory port and the sticky timeout flag.
// slave = arbiter side, master = core + memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic [DW/8-1:0] d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic [DW/8-1:0] mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic            err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Owner selection for the memory port arbiter.
// Default: fixed priority, data over fetch.
// MEM_ARB_RR_EN defined: on a tie the requester not granted last wins.
// The owner register doubles as the last-granted register; it resets to
// fetch so data wins the first tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   take,
  output owner_t pick,
  output owner_t owner
);

`ifdef MEM_ARB_RR_EN
  // Round-robin choice: alternate on ties, otherwise the lone requester.
  always_comb begin
    pick = owner;
    if (if_req && d_req) begin
      pick = other_owner(owner);
    end else if (d_req) begin
      pick = OWN_D;
    end else if (if_req) begin
      pick = OWN_IF;
    end else begin
      pick = owner;
    end
  end
`else
  // Fixed priority choice: data first, then fetch.
  always_comb begin
    pick = owner;
    if (d_req) begin
      pick = OWN_D;
    end else if (if_req) begin
      pick = OWN_IF;
    end else begin
      pick = owner;
    end
  end
`endif

  // Capture the winner at arbitration; it owns the port until the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_IF;
    end else if (take) begin
      owner <= pick;
    end else begin
      owner <= owner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// IDLE -> REQ -> WAIT -> IDLE, one access outstanding at a time; a WAIT
// watchdog returns ERR_DATA and sets the sticky err flag on a hung access.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (default fixed priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_DATA    = ERR_DATA_DEF
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  state_t        state;
  logic [CW-1:0] cnt;
  owner_t        pick;
  owner_t        owner;
  logic          any_req;
  logic          take;
  logic          timeout;
  logic          resp_valid;
  logic [DW-1:0] resp_data;

  assign any_req    = bus.if_req | bus.d_req;
  assign take       = (state == IDLE) && any_req;
  assign timeout    = (state == WAIT) && !bus.mem_rvalid && (cnt == CNT_MAX);
  assign resp_valid = (state == WAIT) && (bus.mem_rvalid || (cnt == CNT_MAX));
  assign resp_data  = bus.mem_rvalid ? bus.mem_rdata : ERR_DATA;

  mem_arb_pick u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .take   (take),
    .pick   (pick),
    .owner  (owner)
  );

  // Transaction FSM: latch the winner's payload, hold mem_req until grant,
  // then count WAIT cycles until a response or the watchdog fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= REQ;
            bus.mem_req <= 1'b1;
            if (pick == OWN_D) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              bus.mem_we    <= '0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            state       <= WAIT;
            bus.mem_req <= 1'b0;
            cnt         <= '0;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            state <= IDLE;
            if (timeout) begin
              bus.err <= 1'b1;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Route grant and response to the current owner only; the other side sees zeros.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    if ((state == REQ) && bus.mem_gnt) begin
      if (owner == OWN_D) begin
        bus.d_gnt = 1'b1;
      end else begin
        bus.if_gnt = 1'b1;
      end
    end else begin
      bus.if_gnt = 1'b0;
    end
    if (resp_valid) begin
      if (owner == OWN_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = resp_data;
      end else begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = resp_data;
      end
    end else begin
      bus.d_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT_CYC = 4).
// Reference model: per-transaction winner/latency/response computed from the
// arbitration rules, plus a sticky error bit.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit m_last_d = 1'b0;   // model: last winner was the data port
  bit m_err    = 1'b0;   // model: sticky timeout flag

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  // One full access starting in an IDLE cycle (just after a rising edge).
  // gdly: extra REQ cycles before mem_gnt; rdly: WAIT cycle index of mem_rvalid
  // (beyond TO means the memory never answers).
  task automatic access(input bit ireq, input bit dreq, input logic [31:0] iaddr,
                        input logic [31:0] daddr, input logic [3:0] dwe,
                        input logic [31:0] dwdata, input int gdly, input int rdly,
                        input logic [31:0] rdat, input bit drop, input bit stray);
    bit win_d;
    bit done;
    bit to;
    int j;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_rdata;
    if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
      win_d = !m_last_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = dreq;
    end
    m_last_d = win_d;
    exp_addr = win_d ? daddr : iaddr;
    exp_we   = win_d ? dwe : 4'h0;

    bus.if_req = ireq; bus.if_addr = iaddr;
    bus.d_req = dreq; bus.d_addr = daddr; bus.d_we = dwe; bus.d_wdata = dwdata;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = stray; bus.mem_rdata = $urandom;
    @(negedge clk);
    chk1("idle_mem_req", bus.mem_req, 1'b0);
    chk1("idle_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("idle_d_rvalid", bus.d_rvalid, 1'b0);
    chk1("idle_gnt", bus.if_gnt | bus.d_gnt, 1'b0);
    @(posedge clk); #1;

    // Payload must already be latched: scramble the request side.
    bus.if_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
    bus.d_we = 4'($urandom);
    if (drop) begin
      bus.if_req = 1'b0; bus.d_req = 1'b0;
    end
    for (int k = 0; k <= gdly; k++) begin
      bus.mem_gnt = (k == gdly);
      bus.mem_rvalid = stray;
      @(negedge clk);
      chk1("req_mem_req", bus.mem_req, 1'b1);
      chk32("req_mem_addr", bus.mem_addr, exp_addr);
      chk32("req_mem_we", {28'h0, bus.mem_we}, {28'h0, exp_we});
      if (win_d) chk32("req_mem_wdata", bus.mem_wdata, dwdata);
      chk1("req_if_gnt", bus.if_gnt, (k == gdly) && !win_d);
      chk1("req_d_gnt", bus.d_gnt, (k == gdly) && win_d);
      chk1("req_rvalid", bus.if_rvalid | bus.d_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    bus.mem_gnt = 1'b0;

    j = 0;
    done = 1'b0;
    to = 1'b0;
    while (!done) begin
      bus.mem_rvalid = (j == rdly);
      bus.mem_rdata  = rdat;
      done = (j == rdly) || (j == TO);
      to   = done && (j != rdly);
      exp_rdata = to ? 32'hDEAD_BEEF : rdat;
      @(negedge clk);
      chk1("wait_mem_req", bus.mem_req, 1'b0);
      chk1("wait_gnt", bus.if_gnt | bus.d_gnt, 1'b0);
      chk1("if_rvalid", bus.if_rvalid, done && !win_d);
      chk1("d_rvalid", bus.d_rvalid, done && win_d);
      if (done && !win_d) chk32("if_rdata", bus.if_rdata, exp_rdata);
      else chk32("if_rdata_idle", bus.if_rdata, 32'h0);
      if (done && win_d) chk32("d_rdata", bus.d_rdata, exp_rdata);
      else chk32("d_rdata_idle", bus.d_rdata, 32'h0);
      chk1("wait_err", bus.err, m_err);
      @(posedge clk); #1;
      j++;
    end
    bus.mem_rvalid = 1'b0;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    if (to) m_err = 1'b1;
    chk1("err_after", bus.err, m_err);
  endtask

  initial begin
    int r;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_we", {28'h0, bus.mem_we}, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_gnt", bus.if_gnt | bus.d_gnt, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single fetch, zero-wait memory.
    access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 0, 0, 32'h13, 1'b0, 1'b0);
    // Collision: store wins first tie, fetch keeps requesting.
    access(1'b1, 1'b1, 32'h104, 32'h2000, 4'b1111, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0, 1'b0);
    // Immediate second tie: round-robin hands it to fetch, fixed priority to data.
    access(1'b1, 1'b1, 32'h104, 32'h2004, 4'b0011, 32'h1234_5678, 0, 1, 32'h77, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, 32'h0, 0, 0, 32'h55, 1'b0, 1'b0);
    // Wait states: grant after 3 stalled REQ cycles, response 5 cycles after grant.
    access(1'b0, 1'b1, 32'h0, 32'h3000, 4'h0, 32'h0, 3, 4, 32'hCAFE_F00D, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      access(r[0], r[1], $urandom, $urandom, 4'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Timeout on a load, then a stray late response in IDLE must be ignored.
    access(1'b0, 1'b1, 32'h0, 32'h4000, 4'h0, 32'h0, 0, 99, 32'h0, 1'b1, 1'b0);
    access(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0, 1, 2, 32'h9999, 1'b0, 1'b1);
    // Random timeouts mixed with normal completions.
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(1, 3);
      access(r[0], r[1], $urandom, $urandom, 4'($urandom), $urandom,
             $urandom_range(0, 2), $urandom_range(0, TO + 2), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT drops the access and clears err.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4444;
    #1;
    chk1("rstw_mem_req", bus.mem_req, 1'b0);
    chk1("rstw_err", bus.err, 1'b0);
    chk32("rstw_mem_addr", bus.mem_addr, 32'h0);
    chk1("rstw_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("rstw_d_rvalid", bus.d_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_rvalid = 1'b0;
    m_err = 1'b0;
    m_last_d = 1'b0;
    access(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
    // Tie right after reset: data wins in both arbitration modes.
    access(1'b1, 1'b1, 32'h404, 32'h5000, 4'b1000, 32'h0F0F_0F0F, 1, 1, 32'h1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
